inst_rom_arbiter: RTL and testbench
===================================

Name: inst_rom_arbiter

Overview:
Shares the single combinational instruction ROM between two requesters. The first is the instruction-fetch stage (IF). The second is the load/store path (LS), used for PC-relative constant loads and debug reads of code space. The block grants at most one requester per cycle, drives ROM chip-enable and address, and registers the 64-bit ROM word back to the winner one cycle later. It sits between pc_reg/IF and mem stage on one side and inst_rom on the other.

Parameters:
ADDR_W, 32, byte address width (matches InstAddrBus)
DATA_W, 64, instruction word width (matches InstBus)
STARVE_LIMIT, 4, consecutive IF-denied cycles after which IF wins over LS
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
if_req  input  1  IF read request, level, held until granted
if_addr  input  ADDR_W  IF byte address, stable while if_req high
if_gnt  output  1  IF request accepted this cycle (combinational)
if_rvalid  output  1  IF read data valid (registered)
if_rdata  output  DATA_W  IF read data
flush  input  1  pipeline flush; squashes in-flight IF response
ls_req  input  1  LS read request, level, held until granted
ls_addr  input  ADDR_W  LS byte address
ls_gnt  output  1  LS request accepted this cycle (combinational)
ls_rvalid  output  1  LS read data valid (registered)
ls_rdata  output  DATA_W  LS read data
ls_err  output  1  valid with ls_rvalid; 1 = misaligned address, data is zero
rom_ce  output  1  ROM chip enable (ChipEnable when a granted access is aligned)
rom_addr  output  ADDR_W  ROM byte address
rom_inst  input  DATA_W  ROM combinational output

Behaviour:
- Reset (rst=0, async): if_rvalid=0, ls_rvalid=0, ls_err=0, if_rdata=0, ls_rdata=0, starvation counter=0, pending-owner register=NONE. rom_ce=ChipDisable and gnt=0 whenever rst=0.
- Arbitration, combinational per cycle:
  - ls_req only -> LS granted.
  - if_req only -> IF granted.
  - Both requesting -> LS wins, unless starve_cnt >= STARVE_LIMIT, in which case IF wins.
- Grant blocking: flush=1 blocks the IF grant in that cycle. LS is unaffected.
- ROM drive: the granted address goes combinationally to rom_addr. rom_ce=1 only when a grant is present and addr[2:0]==0. With no grant, rom_ce=0 and rom_addr holds its last value.
- Latency: a grant in cycle N gives the registered response in cycle N+1.
  - Owner's rvalid is 1 for exactly one cycle.
  - Owner's rdata = rom_inst sampled at the cycle-N edge.
  - The other rvalid is 0.
  - rdata holds its value when rvalid=0.
- Misaligned access (addr[2:0]!=0): the grant is still issued, but the ROM is not enabled.
  - LS: ls_rvalid=1, ls_err=1, ls_rdata=0 in cycle N+1.
  - IF: if_rvalid=1, if_rdata=0. IF alignment is pc_reg's responsibility; no IF error port.
- Starvation counter:
  - Increments when if_req=1, flush=0 and LS is granted; saturates at STARVE_LIMIT.
  - Clears on any IF grant, or when if_req=0.
  - Holds when flush=1 and if_req=1.
- Flush: flush=1 in cycle N+1 forces if_rvalid=0 for the response of an IF grant issued in cycle N. An LS response in flight is always delivered.
- Back-to-back: a new grant is allowed every cycle; the response register is single-entry and overwritten each cycle. Requesters must accept rvalid unconditionally; there is no backpressure.
- Reset mid-operation: any pending response is discarded and nothing is delivered after rst deasserts.
- Small FSM on the registered owner: NONE / IF / LS, next state = the current cycle's grant.

Decomposition:
- Add to defines.v: ArbOwnerNone=2'b00, ArbOwnerIf=2'b01, ArbOwnerLs=2'b10, and StarveLimit. Reuse ChipEnable/ChipDisable, ZeroDoubleWord, InstAddrBus and InstBus.
- One natural sub-module: arb_prio_starve, the combinational priority plus starvation-counter logic. The response register stays in the top level.

Test Plan:
- Reset: hold rst=0 with both reqs high -> all gnt=0, rom_ce=0, rvalid=0; after release, the first grant goes to LS.
- IF alone: if_req=1, if_addr=0x8 -> if_gnt=1, rom_addr=0x8, rom_ce=1 same cycle; next cycle if_rvalid=1, if_rdata=ROM word 1 (0x20e27ffffff60000).
- Contention with STARVE_LIMIT=4: both reqs held -> LS granted 4 cycles, IF granted on the 5th, then LS again and the counter restarts from 0.
- Misaligned LS: ls_addr=0x4 -> ls_gnt=1, rom_ce=0; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0.
- Flush: IF granted at addr 0x0 in cycle N, flush=1 in cycle N+1 -> if_rvalid=0 in N+1, no IF grant in N+1; an LS grant in N+1 still answers in N+2.
- Async reset mid-access: drop rst between grant and response -> rvalid stays 0 and nothing is delivered after rst returns.

Source files
------------

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter: owner encoding,
// chip-enable levels and the doubleword alignment helper.
package inst_rom_arbiter_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 64;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_OWNER_NONE = 2'b00,
    ARB_OWNER_IF   = 2'b01,
    ARB_OWNER_LS   = 2'b10
  } arb_owner_e;

  function automatic logic is_dword_aligned(input logic [2:0] byte_lsb);
    return byte_lsb == 3'b000;
  endfunction

endpackage

// File: rtl/inst_rom_arbiter_prio.sv
// Fixed LS-over-IF priority with a saturating starvation counter that lets IF
// win once it has been denied STARVE_LIMIT consecutive cycles.
module arb_prio_starve #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  input  logic flush,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    starved  = (starve_q >= LIMIT);
    if_gnt   = rst & if_req & ~flush & (~ls_req | starved);
    ls_gnt   = rst & ls_req & ~if_gnt;
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (!flush && ls_gnt && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the combinational instruction ROM between IF and LS: one grant per
// cycle, ROM driven in the grant cycle, single-entry response one cycle later.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W       = INST_ADDR_W,
  parameter int DATA_W       = INST_DATA_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  arb_owner_e        owner_q;
  logic [ADDR_W-1:0] gnt_addr, rom_addr_q;
  logic [DATA_W-1:0] resp_q, if_hold_q, ls_hold_q;
  logic              any_gnt, gnt_aligned, err_q;

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .flush  (flush),
    .if_gnt (if_gnt),
    .ls_gnt (ls_gnt)
  );

  always_comb begin
    any_gnt     = if_gnt | ls_gnt;
    gnt_addr    = if_gnt ? if_addr : ls_addr;
    gnt_aligned = is_dword_aligned(gnt_addr[2:0]);
    rom_ce      = (any_gnt && gnt_aligned) ? CHIP_ENABLE : CHIP_DISABLE;
    rom_addr    = any_gnt ? gnt_addr : rom_addr_q;
    // A flush in the response cycle squashes the IF delivery; LS is never squashed.
    if_rvalid   = (owner_q == ARB_OWNER_IF) && !flush;
    ls_rvalid   = (owner_q == ARB_OWNER_LS);
    ls_err      = ls_rvalid & err_q;
    if_rdata    = if_rvalid ? resp_q : if_hold_q;
    ls_rdata    = ls_rvalid ? resp_q : ls_hold_q;
  end

  // NOTE: the data registers are reset too, because reset must present zero read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= ARB_OWNER_NONE;
      rom_addr_q <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
      if_hold_q  <= '0;
      ls_hold_q  <= '0;
    end else begin
      if (if_gnt)      owner_q <= ARB_OWNER_IF;
      else if (ls_gnt) owner_q <= ARB_OWNER_LS;
      else             owner_q <= ARB_OWNER_NONE;
      if (any_gnt) begin
        rom_addr_q <= gnt_addr;
        resp_q     <= gnt_aligned ? rom_inst : '0;
        err_q      <= ~gnt_aligned;
      end
      if (if_rvalid) if_hold_q <= resp_q;
      if (ls_rvalid) ls_hold_q <= resp_q;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural arbitration model.
module tb_inst_rom_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, rom_ce;
  logic [63:0] if_rdata, ls_rdata, rom_inst;
  logic [31:0] rom_addr;
  logic [63:0] rom_mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom_mem[rom_addr[6:3]];

  inst_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic apply(input logic ir, input logic [31:0] ia, input logic lr,
                       input logic [31:0] la, input logic fl);
    @(negedge clk);
    if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la; flush = fl;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    apply(1'b1, 32'h10, 1'b1, 32'h18, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({if_gnt, ls_gnt, rom_ce} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt_ce: got %b exp 000", {if_gnt, ls_gnt, rom_ce});
    end
    checks++;
    if ({if_rvalid, ls_rvalid, ls_err} !== 3'b000) begin
      errors++; $display("FAIL reset_rvalid: got %b exp 000", {if_rvalid, ls_rvalid, ls_err});
    end
    checks++;
    if ((if_rdata | ls_rdata) !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h exp 0", if_rdata, ls_rdata);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if ({if_gnt, ls_gnt} !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: got if/ls %b exp 01", {if_gnt, ls_gnt});
    end
  endtask

  task automatic test_if_alone;
    apply(1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({if_gnt, ls_gnt, rom_ce, rom_addr} !== {3'b101, 32'h8}) begin
      errors++; $display("FAIL if_alone_grant: got gnt/ce %b addr %h exp 101 8", {if_gnt, ls_gnt, rom_ce}, rom_addr);
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 64'h20e27ffffff60000}) begin
      errors++; $display("FAIL if_alone_resp: got v %b d %h exp 1 20e27ffffff60000", if_rvalid, if_rdata);
    end
    checks++;
    if ({rom_ce, rom_addr} !== {1'b0, 32'h8}) begin
      errors++; $display("FAIL idle_rom_hold: got ce %b addr %h exp 0 8", rom_ce, rom_addr);
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 64'h20e27ffffff60000}) begin
      errors++; $display("FAIL if_rdata_hold: got v %b d %h exp 0 20e27ffffff60000", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_contention;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] exp_g;
      apply(1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
      exp_g = (i % (LIMIT + 1) == LIMIT) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt, ls_gnt} !== exp_g) begin
        errors++; $display("FAIL contention_cycle%0d: got if/ls %b exp %b", i, {if_gnt, ls_gnt}, exp_g);
      end
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned_ls;
    apply(1'b0, 32'h0, 1'b1, 32'h4, 1'b0);
    checks++;
    if ({ls_gnt, rom_ce} !== 2'b10) begin
      errors++; $display("FAIL misaligned_grant: got gnt/ce %b exp 10", {ls_gnt, rom_ce});
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b11, 64'h0}) begin
      errors++; $display("FAIL misaligned_resp: got v/err %b d %h exp 11 0", {ls_rvalid, ls_err}, ls_rdata);
    end
  endtask

  task automatic test_flush;
    apply(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_setup_grant: got %b exp 1", if_gnt);
    end
    apply(1'b1, 32'h8, 1'b1, 32'h18, 1'b1);
    checks++;
    if ({if_gnt, ls_gnt, if_rvalid} !== 3'b010) begin
      errors++; $display("FAIL flush_cycle: got if_gnt/ls_gnt/if_rvalid %b exp 010", {if_gnt, ls_gnt, if_rvalid});
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b10, rom_mem[3]}) begin
      errors++; $display("FAIL flush_ls_delivered: got v %b d %h exp 10 %h", {ls_rvalid, if_rvalid}, ls_rdata, rom_mem[3]);
    end
  endtask

  task automatic test_reset_mid;
    apply(1'b1, 32'h10, 1'b1, 32'h28, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    checks++;
    if ({if_rvalid, ls_rvalid, if_gnt, ls_gnt, rom_ce} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_async: got %b exp 00000", {if_rvalid, ls_rvalid, if_gnt, ls_gnt, rom_ce});
    end
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== {2'b00, 128'h0}) begin
        errors++; $display("FAIL reset_mid_after%0d: got v %b d %h/%h exp 00 0/0", i, {if_rvalid, ls_rvalid}, if_rdata, ls_rdata);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
    return a;
  endfunction

  // Reference model: owner 0 = none, 1 = IF, 2 = LS; starve counts IF denials.
  task automatic test_random;
    int          starve = 0, owner = 0, g;
    logic [63:0] resp = '0, if_hold = '0, ls_hold = '0;
    logic        err = 1'b0, e_ifv, e_lsv, e_ce, ir = 1'b0, lr = 1'b0, fl;
    logic [31:0] last_addr = '0, ia = '0, la = '0, ga;

    rst = 1'b0;
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); rst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      fl = ($urandom_range(0, 5) == 0);
      apply(ir, ia, lr, la, fl);
      if (lr && !(ir && !fl && starve >= LIMIT)) g = 2;
      else if (ir && !fl)                        g = 1;
      else                                        g = 0;
      ga    = (g == 1) ? ia : (g == 2) ? la : last_addr;
      e_ce  = (g != 0) && (ga[2:0] == 3'b000);
      e_ifv = (owner == 1) && !fl;
      e_lsv = (owner == 2);
      checks++;
      if ({if_gnt, ls_gnt, rom_ce, if_rvalid, ls_rvalid, ls_err} !==
          {g == 1, g == 2, e_ce, e_ifv, e_lsv, e_lsv && err}) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d: got gnt/ce/rv/err %b exp %b", cyc,
                 {if_gnt, ls_gnt, rom_ce, if_rvalid, ls_rvalid, ls_err},
                 {g == 1, g == 2, e_ce, e_ifv, e_lsv, e_lsv && err});
      end
      checks++;
      if (rom_addr !== ga) begin
        errors++; $display("FAIL rand_rom_addr cyc%0d: got %h exp %h", cyc, rom_addr, ga);
      end
      checks++;
      if (if_rdata !== (e_ifv ? resp : if_hold)) begin
        errors++; $display("FAIL rand_if_rdata cyc%0d: got %h exp %h", cyc, if_rdata, e_ifv ? resp : if_hold);
      end
      checks++;
      if (ls_rdata !== (e_lsv ? resp : ls_hold)) begin
        errors++; $display("FAIL rand_ls_rdata cyc%0d: got %h exp %h", cyc, ls_rdata, e_lsv ? resp : ls_hold);
      end
      if (e_ifv) if_hold = resp;
      if (e_lsv) ls_hold = resp;
      if (!ir || g == 1)            starve = 0;
      else if (!fl && g == 2)       starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      owner = g;
      if (g != 0) begin
        last_addr = ga;
        err       = (ga[2:0] != 3'b000);
        resp      = err ? 64'h0 : rom_mem[ga[6:3]];
      end
      if (!ir || g == 1) begin ir = ($urandom_range(0, 2) != 0); ia = rand_addr(); end
      if (!lr || g == 2) begin lr = ($urandom_range(0, 2) != 0); la = rand_addr(); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = {$urandom, $urandom};
    rom_mem[1] = 64'h20e27ffffff60000;
    test_reset;
    test_if_alone;
    test_contention;
    test_misaligned_ls;
    test_flush;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
